// File: rtl/fb_byte_loader.sv
// fb_byte_loader
// Framebuffer write front-end. Decodes bytes from the UART receiver into
// pixel writes for the 180x180 2-bit framebuffer RAM array.
//   PIXEL (1xpppppp): three 2-bit pixels written at ptr, ptr+1, ptr+2
//   HOME  (00xxxxxx): ptr <= 0, no write
//   FILL  (01xxxxcc): colour cc written to every address, then ptr <= 0
// Ports:
//   pll_clk   clock
//   i_nrst    asynchronous active-low reset
//   i_valid   one-cycle strobe, i_data holds a received byte
//   i_data    received byte
//   o_we      pixel write enable
//   o_waddr   pixel address (next write address while o_we is low)
//   o_wdata   pixel value
//   o_ack     one-cycle pulse, byte accepted (echo trigger)
//   o_drop    one-cycle pulse, byte discarded while busy
//   o_busy    high while unpacking or filling
//   dbg_state current FSM state (0 idle, 1 unpack, 2 fill)
// Handshake: i_valid has no back-pressure. A strobe seen while the FSM is
// not idle is discarded and answered with o_drop; a strobe seen in idle is
// always accepted and answered with o_ack on the following cycle.
module fb_byte_loader #(
  parameter int NPIX = 32400,
  parameter int AW   = 15
) (
  input  logic          pll_clk,
  input  logic          i_nrst,
  input  logic          i_valid,
  input  logic [7:0]    i_data,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [1:0]    o_wdata,
  output logic          o_ack,
  output logic          o_drop,
  output logic          o_busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UNPACK = 2'd1,
    S_FILL   = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0]    rem_q, rem_d;     // pixels still to write in UNPACK
  logic [3:0]    pix_q, pix_d;     // p1/p2 waiting to be written
  logic          we_d, ack_d, drop_d, busy_d;
  logic [AW-1:0] waddr_d;
  logic [1:0]    wdata_d;

  // Pointer increment with wrap at the last framebuffer address.
  function automatic logic [AW-1:0] inc_addr(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + AW'(1);
  endfunction

  always_ff @(posedge pll_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      pix_q   <= '0;
      o_we    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
      o_ack   <= 1'b0;
      o_drop  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      pix_q   <= pix_d;
      o_we    <= we_d;
      o_waddr <= waddr_d;
      o_wdata <= wdata_d;
      o_ack   <= ack_d;
      o_drop  <= drop_d;
      o_busy  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    pix_d   = pix_q;
    we_d    = 1'b0;
    waddr_d = o_waddr;
    wdata_d = o_wdata;
    ack_d   = 1'b0;
    drop_d  = 1'b0;
    busy_d  = o_busy;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (i_valid) begin
          ack_d = 1'b1;
          if (i_data[7]) begin
            // First pixel goes out right away; p1/p2 are parked in pix.
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = i_data[1:0];
            pix_d   = i_data[5:2];
            ptr_d   = inc_addr(ptr_q);
            rem_d   = 2'd2;
            busy_d  = 1'b1;
            state_d = S_UNPACK;
          end else if (!i_data[6]) begin
            ptr_d   = '0;
            waddr_d = '0;
          end else begin
            // The fill walks o_waddr itself; ptr is reset when it ends.
            we_d    = 1'b1;
            waddr_d = '0;
            wdata_d = i_data[1:0];
            busy_d  = 1'b1;
            state_d = S_FILL;
          end
        end
      end

      S_UNPACK: begin
        drop_d = i_valid;
        if (rem_q != 2'd0) begin
          we_d    = 1'b1;
          waddr_d = ptr_q;
          wdata_d = pix_q[1:0];
          pix_d   = {2'b00, pix_q[3:2]};
          ptr_d   = inc_addr(ptr_q);
          rem_d   = rem_q - 2'd1;
        end else begin
          // Last write was shown last cycle; present the next address.
          waddr_d = ptr_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_FILL: begin
        drop_d = i_valid;
        if (o_waddr == LAST_ADDR) begin
          waddr_d = '0;
          ptr_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          we_d    = 1'b1;
          waddr_d = o_waddr + AW'(1);
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_fb_byte_loader.sv
// Testbench for fb_byte_loader. A reference model turns each byte handed to
// the DUT into the expected write stream (cycle, address, value) and the
// expected ack/drop event; a negedge monitor pops and compares.
module tb_fb_byte_loader;

  localparam int NPIX = 32400;
  localparam int AW   = 15;

  logic          pll_clk;
  logic          i_nrst;
  logic          i_valid;
  logic [7:0]    i_data;
  logic          o_we;
  logic [AW-1:0] o_waddr;
  logic [1:0]    o_wdata;
  logic          o_ack;
  logic          o_drop;
  logic          o_busy;
  logic [1:0]    dbg_state;

  fb_byte_loader #(.NPIX(NPIX), .AW(AW)) dut (
    .pll_clk   (pll_clk),
    .i_nrst    (i_nrst),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_we      (o_we),
    .o_waddr   (o_waddr),
    .o_wdata   (o_wdata),
    .o_ack     (o_ack),
    .o_drop    (o_drop),
    .o_busy    (o_busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    pll_clk = 1'b0;
    forever #5 pll_clk = ~pll_clk;
  end

  int cyc = 0;
  always @(posedge pll_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [48:0] exp_q[$];   // {cycle, addr, value}
  logic [32:0] ev_q[$];    // {cycle, 1=ack / 0=drop}
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [AW-1:0] m_ptr   = '0;
  int            free_at = 0;   // first sampling edge at which a byte is accepted

  task automatic model_byte(input logic [7:0] b, input int n);
    if (n < free_at) begin
      ev_q.push_back({32'(n), 1'b0});
    end else begin
      ev_q.push_back({32'(n), 1'b1});
      if (b[7]) begin
        for (int k = 0; k < 3; k++) begin
          exp_q.push_back({32'(n + k), m_ptr, b[2*k +: 2]});
          m_ptr = AW'((int'(m_ptr) + 1) % NPIX);
        end
        free_at = n + 4;
      end else if (!b[6]) begin
        m_ptr   = '0;
        free_at = n + 1;
      end else begin
        for (int a = 0; a < NPIX; a++)
          exp_q.push_back({32'(n + a), AW'(a), b[1:0]});
        m_ptr   = '0;
        free_at = n + NPIX + 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int k);
    repeat (k) begin
      @(posedge pll_clk);
      #1;
    end
  endtask

  task automatic send_raw(input logic [7:0] b);
    i_valid = 1'b1;
    i_data  = b;
    @(posedge pll_clk);
    #1;
    i_valid = 1'b0;
    i_data  = $urandom_range(0, 255);
    model_byte(b, cyc);
  endtask

  task automatic wait_free();
    while (cyc + 1 < free_at) idle(1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_free();
    send_raw(b);
  endtask

  task automatic check_idle(input string name);
    wait_free();
    n_cmp++;
    if (o_waddr !== m_ptr || o_busy !== 1'b0 || o_we !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: waddr=%0d busy=%b we=%b, required waddr=%0d busy=0 we=0",
               name, o_waddr, o_busy, o_we, m_ptr);
    end
  endtask

  task automatic apply_reset(input int k);
    i_nrst = 1'b0;
    exp_q.delete();
    ev_q.delete();
    m_ptr   = '0;
    free_at = 0;
    repeat (k) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data  = $urandom_range(0, 255);
      idle(1);
    end
    i_valid = 1'b0;
    i_nrst  = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge pll_clk) begin
    if (!i_nrst) begin
      n_cmp++;
      if ({o_we, o_waddr, o_wdata, o_ack, o_drop, o_busy} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: we=%b waddr=%0d wdata=%b ack=%b drop=%b busy=%b, required all 0",
                 o_we, o_waddr, o_wdata, o_ack, o_drop, o_busy);
      end
    end else begin
      n_cmp++;
      if (int'(o_waddr) >= NPIX || (o_ack && o_drop)) begin
        n_fail++;
        $display("FAIL addr_range_excl: waddr=%0d ack=%b drop=%b, required waddr<%0d and not both",
                 o_waddr, o_ack, o_drop, NPIX);
      end
      if (o_we) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected: cycle=%0d addr=%0d val=%b, required no write",
                   cyc, o_waddr, o_wdata);
        end else begin
          logic [48:0] e;
          e = exp_q.pop_front();
          if (e !== {32'(cyc), o_waddr, o_wdata}) begin
            n_fail++;
            $display("FAIL write: cycle=%0d addr=%0d val=%b, required cycle=%0d addr=%0d val=%b",
                     cyc, o_waddr, o_wdata, e[48:17], e[16:2], e[1:0]);
          end
        end
      end
      if (o_ack || o_drop) begin
        n_cmp++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL event_unexpected: cycle=%0d ack=%b drop=%b, required none",
                   cyc, o_ack, o_drop);
        end else begin
          logic [32:0] v;
          v = ev_q.pop_front();
          if (v[32:1] != 32'(cyc) || v[0] != o_ack) begin
            n_fail++;
            $display("FAIL ack_drop: cycle=%0d ack=%b drop=%b, required cycle=%0d ack=%b",
                     cyc, o_ack, o_drop, v[32:1], v[0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    i_nrst  = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    #1;
    i_nrst = 1'b0;
    @(posedge pll_clk);
    #1;
    apply_reset(6);
    idle(10);
    check_idle("after_reset");

    // Pixel unpack
    idle(10);
    send(8'hE4);
    idle(10);
    send(8'h9B);
    check_idle("after_unpack");

    // Home
    send(8'h80);
    send(8'h80);
    send(8'h00);
    send(8'hC1);
    check_idle("after_home");

    // Wrap: one full lap of 0x80 bytes, then 0xBF wraps to 0..2
    send(8'h00);
    for (int i = 0; i < NPIX / 3; i++) send(8'h80);
    send(8'hBF);
    check_idle("after_wrap");

    // Random bytes with random gaps (no fills); bytes may land while busy
    for (int i = 0; i < 300; i++) begin
      logic [7:0] b;
      b = $urandom_range(0, 255);
      if (b[7:6] == 2'b01) b[7] = 1'b1;
      idle($urandom_range(0, 4));
      send_raw(b);
    end
    check_idle("after_random");

    // Fill with a byte dropped 20 cycles in
    send(8'h43);
    idle(19);
    send_raw(8'h80);
    check_idle("after_fill");

    // Reset in the middle of a fill
    begin
      int n0;
      send(8'h42);
      n0 = cyc;
      while (cyc < n0 + 99) idle(1);
      apply_reset(3);
    end
    send(8'h81);
    check_idle("after_reset_fill");

    idle(5);
    n_cmp++;
    if (exp_q.size() != 0 || ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: writes=%0d events=%0d, required 0/0", exp_q.size(), ev_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL timeout: cycle=%0d, required completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
